// File: rtl/conv_result_saver.sv
// Consumer end of the conv pixel handshake: stores/accumulates each pixel into an
// output feature-map buffer, acks the conv engine, and tracks channel/layer progress.
module conv_result_saver #(
   parameter int OUT_H1    = 14,
   parameter int OUT_W1    = 13,
   parameter int OUT_H2    = 12,
   parameter int OUT_W2    = 11,
   parameter int ACC_WIDTH = 16,
   parameter int BUF_DEPTH = 182
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 layer,
   input  logic [3:0]           num_ch,
   input  logic                 valid,
   input  logic [7:0]           in_pixel,
   output logic                 save_done,
   output logic                 ch_done,
   output logic                 layer_done,
   output logic                 err,
   input  logic [7:0]           rd_addr,
   output logic [ACC_WIDTH-1:0] rd_data
);

   localparam int N_PIX1 = OUT_H1 * OUT_W1;
   localparam int N_PIX2 = OUT_H2 * OUT_W2;
   // One spare bit above max(ACC_WIDTH, 9) so buffer + pixel never wraps before saturation.
   localparam int EXT_W  = ((ACC_WIDTH > 9) ? ACC_WIDTH : 9) + 1;
   localparam logic signed [EXT_W-1:0] SAT_MAX =
      {{(EXT_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN =
      {{(EXT_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
   localparam logic [8:0] DEPTH_LIM = 9'(BUF_DEPTH);

   typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

   state_t                  state;
   logic [7:0]              pixel_q;
   logic [7:0]              pix_cnt;
   logic [3:0]              ch_cnt;
   logic [ACC_WIDTH-1:0]    fmap [BUF_DEPTH];

   logic [7:0]              pix_last;
   logic [3:0]              ch_last;
   logic                    pix_wrap;
   logic                    ch_wrap;
   logic [ACC_WIDTH-1:0]    cur_val;
   logic signed [EXT_W-1:0] pix_ext;
   logic signed [EXT_W-1:0] acc_ext;
   logic signed [EXT_W-1:0] sum;
   logic [ACC_WIDTH-1:0]    wr_value;

   // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      pix_last = layer ? 8'(N_PIX2 - 1) : 8'(N_PIX1 - 1);
      ch_last  = (num_ch == 4'd0) ? 4'd0 : num_ch - 4'd1;
      pix_wrap = (pix_cnt == pix_last);
      ch_wrap  = (ch_cnt == ch_last);
      cur_val  = fmap[pix_cnt];
      pix_ext  = {{(EXT_W-8){layer & pixel_q[7]}}, pixel_q};
      // The first channel overwrites, so the buffer never needs clearing between passes.
      acc_ext  = (ch_cnt == 4'd0) ? '0 : {{(EXT_W-ACC_WIDTH){cur_val[ACC_WIDTH-1]}}, cur_val};
      sum      = acc_ext + pix_ext;
      if (sum > SAT_MAX)
         wr_value = SAT_MAX[ACC_WIDTH-1:0];
      else if (sum < SAT_MIN)
         wr_value = SAT_MIN[ACC_WIDTH-1:0];
      else
         wr_value = sum[ACC_WIDTH-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pixel_q    <= '0;
         pix_cnt    <= '0;
         ch_cnt     <= '0;
         save_done  <= 1'b0;
         ch_done    <= 1'b0;
         layer_done <= 1'b0;
         err        <= 1'b0;
      end else if (start) begin
         state      <= IDLE;
         pix_cnt    <= '0;
         ch_cnt     <= '0;
         save_done  <= 1'b0;
         ch_done    <= 1'b0;
         layer_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         save_done <= 1'b0;
         ch_done   <= 1'b0;
         if (valid && state != IDLE)
            err <= 1'b1;
         case (state)
            IDLE: begin
               if (valid) begin
                  pixel_q <= in_pixel;
                  state   <= WRITE;
               end
            end
            WRITE: begin
               state     <= ACK;
               save_done <= 1'b1;
               ch_done   <= pix_wrap;
            end
            ACK: begin
               state <= IDLE;
               if (pix_wrap) begin
                  pix_cnt <= '0;
                  if (ch_wrap) begin
                     ch_cnt     <= '0;
                     layer_done <= 1'b1;
                  end else begin
                     ch_cnt <= ch_cnt + 4'd1;
                  end
               end else begin
                  pix_cnt <= pix_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the buffer array has no reset; its contents survive rst_n and start by design.
   always_ff @(posedge clk) begin
      if (rst_n && !start && state == WRITE)
         fmap[pix_cnt] <= wr_value;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         rd_data <= '0;
      else if ({1'b0, rd_addr} < DEPTH_LIM)
         rd_data <= fmap[rd_addr];
      else
         rd_data <= '0;
   end

endmodule

// File: tb/tb_conv_result_saver.sv
// Self-checking bench for conv_result_saver: directed passes, a vector table,
// randomized passes against a behavioural buffer model, and handshake corner cases.
module tb_conv_result_saver;

   logic        clk = 1'b0;
   logic        rst_n, start, layer, valid;
   logic [3:0]  num_ch;
   logic [7:0]  in_pixel, rd_addr;
   logic        save_done, ch_done, layer_done, err;
   logic [15:0] rd16;
   logic        save_done8, ch_done8, layer_done8, err8;
   logic [7:0]  rd8;

   conv_result_saver dut (
      .clk(clk), .rst_n(rst_n), .start(start), .layer(layer), .num_ch(num_ch),
      .valid(valid), .in_pixel(in_pixel), .save_done(save_done), .ch_done(ch_done),
      .layer_done(layer_done), .err(err), .rd_addr(rd_addr), .rd_data(rd16)
   );

   conv_result_saver #(.ACC_WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .layer(layer), .num_ch(num_ch),
      .valid(valid), .in_pixel(in_pixel), .save_done(save_done8), .ch_done(ch_done8),
      .layer_done(layer_done8), .err(err8), .rd_addr(rd_addr), .rd_data(rd8)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int ch_seen = 0;

   // Behavioural model: buffer contents per accumulator width plus progress counters.
   int m16 [182];
   int m8  [182];
   int m_layer, m_nch, m_pix, m_ch, m_ld, m_err;

   typedef struct {
      logic       lay;
      logic [3:0] nch;
      logic [7:0] pix;
      int         exp16;
      int         exp8;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int w);
      int mx = (1 << (w - 1)) - 1;
      if (v > mx) return mx;
      if (v < -mx - 1) return -mx - 1;
      return v;
   endfunction

   function automatic int n_pix();
      return m_layer ? 132 : 182;
   endfunction

   task automatic model_store(input logic [7:0] p);
      int e = m_layer ? int'($signed(p)) : int'(p);
      if (m_ch == 0) begin
         m16[m_pix] = sat(e, 16);
         m8[m_pix]  = sat(e, 8);
      end else begin
         m16[m_pix] = sat(m16[m_pix] + e, 16);
         m8[m_pix]  = sat(m8[m_pix] + e, 8);
      end
      if (m_pix == n_pix() - 1) begin
         m_pix = 0;
         if (m_ch == m_nch - 1) begin
            m_ch = 0;
            m_ld = 1;
         end else begin
            m_ch++;
         end
      end else begin
         m_pix++;
      end
   endtask

   task automatic cfg(input logic lay, input logic [3:0] nch);
      layer  = lay;
      num_ch = nch;
      m_layer = lay;
      m_nch   = (nch == 0) ? 1 : int'(nch);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      m_pix = 0; m_ch = 0; m_ld = 0; m_err = 0;
      check("start_clears_err", err, 0);
      check("start_clears_layer_done", layer_done, 0);
   endtask

   // One pixel through the handshake, waiting for the ack before returning.
   task automatic send(input logic [7:0] p);
      bit last = (m_pix == n_pix() - 1);
      @(posedge clk); #1 valid = 1'b1; in_pixel = p;
      @(posedge clk); #1 valid = 1'b0;
      check("save_done_early", save_done, 0);
      @(posedge clk); #1;
      check("save_done", save_done, 1);
      check("ch_done", ch_done, last);
      check("layer_done_hold", layer_done, m_ld);
      check("err", err, m_err);
      if (ch_done) ch_seen++;
      model_store(p);
   endtask

   task automatic read_at(input logic [7:0] a, output logic [15:0] r16, output logic [7:0] r8);
      @(posedge clk); #1 rd_addr = a;
      @(posedge clk); #1 r16 = rd16; r8 = rd8;
   endtask

   task automatic run_pass(input logic lay, input logic [3:0] nch, input bit rnd,
                           input logic [7:0] fixed);
      int total;
      cfg(lay, nch);
      total = n_pix() * m_nch;
      ch_seen = 0;
      for (int i = 0; i < total; i++)
         send(rnd ? 8'($urandom) : fixed);
      @(posedge clk); #1;
      check("layer_done_set", layer_done, 1);
      check("ch_done_count", ch_seen, m_nch);
   endtask

   initial begin
      logic [15:0] r16;
      logic [7:0]  r8;
      int          seen;
      int          oldv;

      tbl[0] = '{1'b0, 4'd1, 8'h05,    5,    5};
      tbl[1] = '{1'b1, 4'd3, 8'hFE,   -6,   -6};
      tbl[2] = '{1'b1, 4'd2, 8'h7F,  254,  127};
      tbl[3] = '{1'b0, 4'd2, 8'hFF,  510,  127};
      tbl[4] = '{1'b1, 4'd1, 8'h80, -128, -128};
      tbl[5] = '{1'b0, 4'd0, 8'h10,   16,   16};

      rst_n = 1'b0; start = 1'b0; layer = 1'b0; num_ch = 4'd1;
      valid = 1'b0; in_pixel = 8'h00; rd_addr = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_save_done", save_done, 0);
      check("rst_ch_done", ch_done, 0);
      check("rst_layer_done", layer_done, 0);
      check("rst_err", err, 0);
      check("rst_rd_data", rd16, 0);
      rst_n = 1'b1;

      // Conv1 single channel, pixel = address.
      cfg(1'b0, 4'd1);
      ch_seen = 0;
      for (int i = 0; i < 182; i++) send(8'(i));
      @(posedge clk); #1;
      check("t1_layer_done", layer_done, 1);
      check("t1_ch_done_count", ch_seen, 1);
      for (int i = 0; i < 182; i++) begin
         read_at(8'(i), r16, r8);
         check("t1_buf", $signed(r16), i & 255);
      end

      // Read-during-write on entry 5, then out-of-range reads.
      cfg(1'b0, 4'd1);
      for (int i = 0; i < 5; i++) send(8'(i));
      oldv = m16[5];
      @(posedge clk); #1 valid = 1'b1; in_pixel = 8'h5A;
      @(posedge clk); #1 valid = 1'b0; rd_addr = 8'd5;
      @(posedge clk); #1;
      check("rdw_old_value", $signed(rd16), 5);
      check("rdw_old_model", $signed(rd16), oldv);
      check("rdw_save_done", save_done, 1);
      model_store(8'h5A);
      @(posedge clk); #1;
      check("rdw_new_value", $signed(rd16), 8'h5A);
      read_at(8'd200, r16, r8);
      check("rd_oob_200", r16, 0);
      read_at(8'd255, r16, r8);
      check("rd_oob_255", r16, 0);
      read_at(8'd181, r16, r8);
      check("rd_last_entry", $signed(r16), m16[181]);

      // Vector table: constant pixel through every channel of a layer.
      for (int v = 0; v < 6; v++) begin
         run_pass(tbl[v].lay, tbl[v].nch, 1'b0, tbl[v].pix);
         for (int k = 0; k < 3; k++) begin
            logic [7:0] a;
            a = (k == 0) ? 8'd0 : (k == 1) ? 8'd65 : 8'(n_pix() - 1);
            read_at(a, r16, r8);
            check("tbl_acc16", $signed(r16), tbl[v].exp16);
            check("tbl_acc8", $signed(r8), tbl[v].exp8);
         end
      end

      // Randomized passes against the model, full buffer readback.
      for (int p = 0; p < 3; p++) begin
         run_pass(1'($urandom), 4'($urandom_range(1, 2)), 1'b1, 8'h00);
         for (int i = 0; i < 182; i++) begin
            read_at(8'(i), r16, r8);
            check("rnd_acc16", $signed(r16), m16[i]);
            check("rnd_acc8", $signed(r8), m8[i]);
         end
      end

      // Second valid while busy: flagged, ignored, single ack.
      cfg(1'b0, 4'd1);
      @(posedge clk); #1 valid = 1'b1; in_pixel = 8'h11;
      @(posedge clk); #1 in_pixel = 8'h22;
      @(posedge clk); #1 valid = 1'b0;
      check("busy_save_done", save_done, 1);
      check("busy_err", err, 1);
      model_store(8'h11);
      m_err = 1;
      seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (save_done) seen++;
      end
      check("busy_single_ack", seen, 0);
      read_at(8'd0, r16, r8);
      check("busy_first_kept", $signed(r16), 8'h11);
      check("busy_err_sticky", err, 1);

      // Reset during WRITE drops the pixel and clears everything.
      cfg(1'b0, 4'd1);
      oldv = m16[0];
      @(posedge clk); #1 valid = 1'b1; in_pixel = 8'hC3;
      @(posedge clk); #1 valid = 1'b0; rst_n = 1'b0;
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (save_done) seen++;
      end
      check("rstw_no_ack", seen, 0);
      check("rstw_rd_data", rd16, 0);
      check("rstw_err", err, 0);
      check("rstw_layer_done", layer_done, 0);
      rst_n = 1'b1;
      m_pix = 0; m_ch = 0; m_ld = 0; m_err = 0;
      read_at(8'd0, r16, r8);
      check("rstw_buf_kept", $signed(r16), oldv);

      // start and valid together: start wins.
      @(posedge clk); #1 start = 1'b1; valid = 1'b1; in_pixel = 8'h77;
      @(posedge clk); #1 start = 1'b0; valid = 1'b0;
      seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (save_done) seen++;
      end
      check("startv_no_ack", seen, 0);
      read_at(8'd0, r16, r8);
      check("startv_buf_kept", $signed(r16), oldv);
      send(8'h33);
      read_at(8'd0, r16, r8);
      check("post_rst_pix0", $signed(r16), 8'h33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
